// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes and the multiply sequencer state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_XORI = 4'd6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_step.sv
// mul_step: one combinational shift-add iteration consuming BITS_PER_CYCLE
// multiplier bits. Products are truncated to WIDTH (modulo 2^WIDTH).
module mul_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH-1:0]          acc,
  input  logic [WIDTH-1:0]          mcand,
  input  logic [WIDTH-1:0]          mplier,
  output logic [WIDTH-1:0]          acc_next,
  output logic [WIDTH-1:0]          mcand_next,
  output logic [WIDTH-1:0]          mplier_next
);

  logic [BITS_PER_CYCLE-1:0] digit;
  logic [WIDTH-1:0]          partial;

  // Add mcand times the low multiplier digit, then advance both operands.
  always_comb begin
    digit   = mplier[BITS_PER_CYCLE-1:0];
    partial = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (digit[i]) partial = partial + (mcand << i);
    end
    acc_next    = acc + partial;
    mcand_next  = mcand << BITS_PER_CYCLE;
    mplier_next = mplier >> BITS_PER_CYCLE;
  end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add MUL controller beside the ALU.
// Stalls the core while iterating and pulses done for one commit cycle.
// Optional build macro MUL_EARLY_TERM_EN: leave RUN once the remaining
// multiplier is zero instead of running the full WIDTH/BITS_PER_CYCLE steps.
// BITS_PER_CYCLE must divide WIDTH (legal values 1, 2, 4).
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter logic [3:0]  MUL_SEL        = ALU_MUL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       sel_signal,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW    = $clog2(STEPS) + 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  mul_state_t state, state_n;

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] step_acc, step_mcand, step_mplier;
  logic             issue;

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc         (acc),
    .mcand       (mcand),
    .mplier      (mplier),
    .acc_next    (step_acc),
    .mcand_next  (step_mcand),
    .mplier_next (step_mplier)
  );

  // Next-state decode and combinational outputs.
  always_comb begin
    state_n = state;
    issue   = (state == IDLE) && start && (sel_signal == MUL_SEL);
    case (state)
      IDLE: if (issue) state_n = RUN;
      RUN: begin
        if (count == LAST) state_n = DONE;
`ifdef MUL_EARLY_TERM_EN
        if (step_mplier == '0) state_n = DONE;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    stall = issue || (state == RUN);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath: latch operands at issue, iterate in RUN, capture result on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (issue) begin
          acc    <= '0;
          mcand  <= a;
          mplier <= b;
          count  <= '0;
        end
        RUN: begin
          acc    <= step_acc;
          mcand  <= step_mcand;
          mplier <= step_mplier;
          count  <= count + 1'b1;
          if (state_n == DONE) result <= step_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a result scoreboard and latency model.
module tb_mul_sequencer;
  import alu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned B = 1;
  localparam int unsigned N = W / B;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [3:0]   sel_signal;
  logic [W-1:0] a, b;
  logic         stall, busy, done;
  logic [W-1:0] result;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_res;

  mul_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(B), .MUL_SEL(ALU_MUL)) dut (
    .clk(clk), .rst(rst), .start(start), .sel_signal(sel_signal),
    .a(a), .b(b), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle in which done is expected, counting the issue cycle as 0.
  function automatic int unsigned exp_lat(input logic [W-1:0] bv);
`ifdef MUL_EARLY_TERM_EN
    logic [W-1:0] v = bv;
    int unsigned  r = 0;
    do begin
      v = v >> B;
      r++;
    end while (v != '0);
    return r + 1;
`else
    return N + 1 + 0 * int'(bv[0]);
`endif
  endfunction

  function automatic logic [W-1:0] model_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return p[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a MUL issue in the current cycle and record the expected product.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; sel_signal = ALU_MUL; a = av; b = bv;
    sb.push_back(model_mul(av, bv));
    last_res = model_mul(av, bv);
    #1;
    check("issue_stall", W'(stall), W'(1));
  endtask

  // Advance until done; check latency, run flags and the scoreboard entry.
  task automatic wait_done(input int unsigned lat, input bit hold);
    int unsigned cyc = 0;
    int unsigned bad = 0;
    bit seen = 0;
    while (!seen && cyc < 100) begin
      step();
      cyc++;
      if (!hold) begin
        start = $urandom_range(0, 1);
        a = $urandom; b = $urandom;
      end
      #1;
      if (done) begin
        seen = 1;
        check("done_cycle", W'(cyc), W'(lat));
        check("done_stall", W'(stall), W'(0));
        check("done_busy", W'(busy), W'(0));
        if (sb.size() == 0) check("sb_empty", W'(1), W'(0));
        else check("result", result, sb.pop_front());
      end else if (!(busy && stall)) begin
        bad++;
      end
    end
    check("run_flags_bad_cycles", W'(bad), W'(0));
    check("timeout", W'(seen), W'(1));
    if (!hold) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sel_signal = ALU_ADD; a = '0; b = '0;
    last_res = '0;
    step(); step();
    check("rst_stall", W'(stall), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, '0);
    rst = 1'b0;
    step();

    // Basic products, signed-looking operands and overflow.
    issue(32'd3, 32'd5);               wait_done(exp_lat(32'd5), 0);
    step();
    issue(32'hFFFF_FFFD, 32'd7);       wait_done(exp_lat(32'd7), 0);
    check("neg_const", last_res, 32'hFFFF_FFEB);
    step();
    issue(32'h0001_0000, 32'h0001_0000); wait_done(exp_lat(32'h0001_0000), 0);
    step();

    // Non-MUL select with start high is ignored.
    begin
      int unsigned bad = 0;
      start = 1'b1; sel_signal = ALU_ADD; a = 32'd4; b = 32'd4;
      for (int i = 0; i < 6; i++) begin
        #1;
        if (stall || busy || done) bad++;
        step();
      end
      check("nonmul_flags", W'(bad), W'(0));
      check("nonmul_result", result, last_res);
      start = 1'b0;
    end

    // Reset during RUN: no done pulse, outputs back to reset values.
    start = 1'b1; sel_signal = ALU_MUL; a = 32'd9; b = 32'd9;
    for (int c = 0; c < 10; c++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("midrst_stall", W'(stall), W'(0));
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_result", result, '0);
    step();
    issue(32'd9, 32'd9);               wait_done(exp_lat(32'd9), 0);
    check("post_rst_81", last_res, 32'd81);
    step();

    // Back-to-back: start held through DONE must not re-issue there.
    issue(32'd12, 32'd11);             wait_done(exp_lat(32'd11), 1);
    step();
    issue(32'd1000, 32'd77);
    check("b2b_busy_idle", W'(busy), W'(0));
    wait_done(exp_lat(32'd77), 0);
    step();

    // Early-termination boundary cases (full latency without the macro).
    issue(32'd6, 32'd1);               wait_done(exp_lat(32'd1), 0);
    step();
    issue(32'd6, 32'd0);               wait_done(exp_lat(32'd0), 0);
    step();

    // A few random operands.
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom; rb = $urandom;
      issue(ra, rb);
      wait_done(exp_lat(rb), 0);
      step();
    end

    check("sb_drained", W'(sb.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle shift-add multiplier controller that takes the MUL operation off the single-cycle ALU path.
- Sits beside the ALU. When the ALU select code equals the MUL code, it stalls the core, iterates the product, then releases the stall for one commit cycle.
- Returns the low WIDTH bits of the product, which are identical for signed and unsigned operands.

Parameters:
- WIDTH, 32: operand and result width.
- BITS_PER_CYCLE, 1: multiplier bits consumed per RUN cycle. Must divide WIDTH. Legal values are 1, 2, 4.
- MUL_SEL, 4'd2: ALU select code that identifies MUL.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  current instruction is valid for issue
- sel_signal  in  4  ALU select code from the ALU control decoder
- a  in  WIDTH  multiplicand (rs)
- b  in  WIDTH  multiplier (rt)
- stall  out  1  hold PC and instruction; combinational
- busy  out  1  high while the iteration is running
- done  out  1  one-cycle pulse; result valid for commit
- result  out  WIDTH  product, low WIDTH bits

Behaviour:
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: result=0, busy=0, done=0, stall=0. Internal accumulator, shifted multiplicand, remaining multiplier and step counter are all 0.
- Issue condition: issue = state==IDLE && start && sel_signal==MUL_SEL.
- IDLE: on issue, load mcand=a, mplier=b, acc=0, count=0, then go to RUN. Otherwise stay in IDLE.
- RUN, each cycle:
  - acc += mcand * mplier[BITS_PER_CYCLE-1:0], truncated to WIDTH.
  - mcand <<= BITS_PER_CYCLE.
  - mplier >>= BITS_PER_CYCLE (logical shift).
  - count++.
  - When count reaches WIDTH/BITS_PER_CYCLE-1 on this cycle, go to DONE.
- DONE:
  - result <= final acc, registered on the RUN→DONE edge.
  - done=1 for exactly this cycle; stall=0 so the core commits.
  - Always return to IDLE. start is ignored here, because the same instruction is still present.
- Latency: issue in cycle 0 gives RUN in cycles 1..N with N=WIDTH/BITS_PER_CYCLE, and done in cycle N+1. For defaults, done is at cycle 33.
- Output decode:
  - stall = issue || state==RUN.
  - busy = state==RUN.
- result holds its value until the next RUN→DONE update.
- Non-MUL codes with start=1: ignored. stall=0 and no state change.
- start or operand changes during RUN: ignored, because operands were latched at issue.
- Reset mid-RUN or in DONE: next cycle is IDLE with all outputs at reset values. No done pulse is produced.
- Arithmetic: modulo 2^WIDTH. Overflow bits are discarded silently.
- b=0 or a=0: full latency unless the optional feature is enabled.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in RUN, if the post-shift mplier==0, go to DONE on the next edge regardless of count.
  - Latency becomes ceil(msb_index(b)+1 / BITS_PER_CYCLE) RUN cycles.
  - b=0 takes 1 RUN cycle.
  - done and result semantics are unchanged.
- Undefined: fixed WIDTH/BITS_PER_CYCLE RUN cycles. The zero-detect logic is not present.

Decomposition:
- Shared package alu_pkg holds:
  - ALU select constants: ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_MUL=4'd2, ALU_SLT=4'd3, ALU_SLL=4'd4, ALU_XORI=4'd6.
  - mul_state_t enum {IDLE, RUN, DONE}.
- MUL_SEL defaults to ALU_MUL.
- One sub-module, mul_step: combinational. It takes acc, mcand and the low mplier bits and produces the next acc, mcand and mplier. The FSM and registers stay in mul_sequencer.

Test Plan:
- a=3, b=5, MUL issue at cycle 0 → stall=1 for cycles 0..32, busy=1 for cycles 1..32, done=1 and result=15 at cycle 33, stall=0 at cycle 33.
- a=0xFFFFFFFD (-3), b=7 → result=0xFFFFFFEB at done. Then a=0x00010000, b=0x00010000 → result=0.
- start=1 with sel_signal=ALU_ADD → stall=0, busy=0, done never asserts, result unchanged.
- Issue with a=9, b=9; assert rst at cycle 10 → cycle 11 is IDLE with stall=busy=done=0 and result=0. A new issue then completes normally with 81.
- Back-to-back: start held high with MUL through DONE → no re-issue in DONE. A second issue in the following IDLE cycle produces its own done 33 cycles later.
- With MUL_EARLY_TERM_EN: a=6, b=1 → done at cycle 2, result=6. a=6, b=0 → done at cycle 2, result=0. Without the macro, both cases give done at cycle 33.
